// File: rtl/ysyx_25020037_alu_arb.sv
// Two-requester arbiter in front of the shared core ALU.
// One issue slot drives the ALU and each requester has a one-entry response buffer.
module ysyx_25020037_alu_arb #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 17,
  parameter int RR_EN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [OP_W-1:0]   m0_req_op,
  input  logic              m0_req_dbl,
  input  logic [4*XLEN-1:0] m0_req_src,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [XLEN-1:0]   m0_rsp_result1,
  output logic              m0_rsp_result2,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [OP_W-1:0]   m1_req_op,
  input  logic              m1_req_dbl,
  input  logic [4*XLEN-1:0] m1_req_src,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [XLEN-1:0]   m1_rsp_result1,
  output logic              m1_rsp_result2,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_double_cal,
  output logic [XLEN-1:0]   alu_src1,
  output logic [XLEN-1:0]   alu_src2,
  output logic [XLEN-1:0]   alu_src3,
  output logic [XLEN-1:0]   alu_src4,
  input  logic [XLEN-1:0]   alu_result1,
  input  logic              alu_result2,
  output logic              busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid holds its payload until that edge, and ready may depend on valid.

  logic              iss_v_q, iss_v_d;
  logic              iss_own_q, iss_own_d;
  logic [OP_W-1:0]   iss_op_q, iss_op_d;
  logic              iss_dbl_q, iss_dbl_d;
  logic [4*XLEN-1:0] iss_src_q, iss_src_d;
  logic              rsp0_v_q, rsp0_v_d;
  logic [XLEN-1:0]   rsp0_r1_q, rsp0_r1_d;
  logic              rsp0_r2_q, rsp0_r2_d;
  logic              rsp1_v_q, rsp1_v_d;
  logic [XLEN-1:0]   rsp1_r1_q, rsp1_r1_d;
  logic              rsp1_r2_q, rsp1_r2_d;
  logic              last_grant_q, last_grant_d;

  logic              rr_mode;
  logic              rsp_pop0, rsp_pop1;
  logic              own_v, own_pop;
  logic              iss_adv, slot_free;
  logic              grant_m1;
  logic              acc0, acc1;
  logic [4*XLEN-1:0] src_g;

  assign rr_mode = (RR_EN != 0);

  always_comb begin
    rsp_pop0  = rsp0_v_q & m0_rsp_ready;
    rsp_pop1  = rsp1_v_q & m1_rsp_ready;
    own_v     = iss_own_q ? rsp1_v_q : rsp0_v_q;
    own_pop   = iss_own_q ? rsp_pop1 : rsp_pop0;
    iss_adv   = iss_v_q & (~own_v | own_pop);
    slot_free = ~iss_v_q | iss_adv;
    // On a tie, round-robin hands the slot to whoever did not win last time.
    grant_m1  = m1_req_valid & (~m0_req_valid | (rr_mode & ~last_grant_q));
  end

  // Ready is gated by reset so nothing handshakes while the block is held.
  assign m0_req_ready = reset_n & slot_free & ~grant_m1;
  assign m1_req_ready = reset_n & slot_free & grant_m1;
  assign acc0         = m0_req_valid & m0_req_ready;
  assign acc1         = m1_req_valid & m1_req_ready;

  always_comb begin
    iss_v_d      = iss_v_q;
    iss_own_d    = iss_own_q;
    iss_op_d     = iss_op_q;
    iss_dbl_d    = iss_dbl_q;
    iss_src_d    = iss_src_q;
    last_grant_d = last_grant_q;
    if (acc0 | acc1) begin
      iss_v_d      = 1'b1;
      iss_own_d    = acc1;
      iss_op_d     = acc1 ? m1_req_op  : m0_req_op;
      iss_dbl_d    = acc1 ? m1_req_dbl : m0_req_dbl;
      iss_src_d    = acc1 ? m1_req_src : m0_req_src;
      last_grant_d = acc1;
    end else if (iss_adv) begin
      iss_v_d = 1'b0;
    end
  end

  // A write into a buffer wins over a pop of the same buffer in the same cycle.
  always_comb begin
    rsp0_v_d  = rsp0_v_q;
    rsp0_r1_d = rsp0_r1_q;
    rsp0_r2_d = rsp0_r2_q;
    rsp1_v_d  = rsp1_v_q;
    rsp1_r1_d = rsp1_r1_q;
    rsp1_r2_d = rsp1_r2_q;
    if (iss_adv && !iss_own_q) begin
      rsp0_v_d  = 1'b1;
      rsp0_r1_d = alu_result1;
      rsp0_r2_d = alu_result2;
    end else if (rsp_pop0) begin
      rsp0_v_d = 1'b0;
    end
    if (iss_adv && iss_own_q) begin
      rsp1_v_d  = 1'b1;
      rsp1_r1_d = alu_result1;
      rsp1_r2_d = alu_result2;
    end else if (rsp_pop1) begin
      rsp1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_v_q      <= 1'b0;
      iss_own_q    <= 1'b0;
      iss_op_q     <= '0;
      iss_dbl_q    <= 1'b0;
      iss_src_q    <= '0;
      rsp0_v_q     <= 1'b0;
      rsp0_r1_q    <= '0;
      rsp0_r2_q    <= 1'b0;
      rsp1_v_q     <= 1'b0;
      rsp1_r1_q    <= '0;
      rsp1_r2_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      iss_v_q      <= iss_v_d;
      iss_own_q    <= iss_own_d;
      iss_op_q     <= iss_op_d;
      iss_dbl_q    <= iss_dbl_d;
      iss_src_q    <= iss_src_d;
      rsp0_v_q     <= rsp0_v_d;
      rsp0_r1_q    <= rsp0_r1_d;
      rsp0_r2_q    <= rsp0_r2_d;
      rsp1_v_q     <= rsp1_v_d;
      rsp1_r1_q    <= rsp1_r1_d;
      rsp1_r2_q    <= rsp1_r2_d;
      last_grant_q <= last_grant_d;
    end
  end

  // The ALU sees all-zero inputs whenever the slot is empty.
  assign src_g          = iss_v_q ? iss_src_q : '0;
  assign alu_op         = iss_v_q ? iss_op_q : '0;
  assign alu_double_cal = iss_v_q & iss_dbl_q;
  assign alu_src1       = src_g[XLEN-1:0];
  assign alu_src2       = src_g[2*XLEN-1:XLEN];
  assign alu_src3       = src_g[3*XLEN-1:2*XLEN];
  assign alu_src4       = src_g[4*XLEN-1:3*XLEN];

  assign m0_rsp_valid   = rsp0_v_q;
  assign m0_rsp_result1 = rsp0_r1_q;
  assign m0_rsp_result2 = rsp0_r2_q;
  assign m1_rsp_valid   = rsp1_v_q;
  assign m1_rsp_result1 = rsp1_r1_q;
  assign m1_rsp_result2 = rsp1_r2_q;
  assign busy           = iss_v_q | rsp0_v_q | rsp1_v_q;

endmodule
